trdb_stream_arbiter: RTL

Shares the single outgoing trace word stream between three requesters:
- trace packet words (encoder),
- timer packet words (timer unit),
- software dump words (software FIFO output).

The block arbitrates on packet boundaries, tags each word with its source, and drives a one-entry registered output stage toward the packet streamer. It also sequences the stream flush: it drains the in-flight packet, then confirms the flush back to the control registers.

---
 rtl/trdb_pkg.sv | 22 ++
 rtl/trdb_stream_slice.sv | 36 +++
 rtl/trdb_stream_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace stream arbiter.
// Holds the source tags, the arbiter FSM states and the starvation counter defaults.
package trdb_pkg;

  typedef enum logic [1:0] {
    TRDB_SRC_TRC = 2'd0,
    TRDB_SRC_TIM = 2'd1,
    TRDB_SRC_SW  = 2'd2
  } trdb_src_e;

  typedef enum logic [2:0] {
    TRDB_ARB_IDLE,
    TRDB_ARB_LOCK_TRC,
    TRDB_ARB_LOCK_TIM,
    TRDB_ARB_DRAIN,
    TRDB_ARB_FLUSH_ACK
  } trdb_arb_state_e;

  localparam int unsigned TRDB_ARB_MAX_WAIT = 64;
  localparam int unsigned TRDB_ARB_CNT_W    = 8;

endpackage

// File: rtl/trdb_stream_slice.sv
// One-entry registered valid/ready stage; accepts a new word whenever it is empty
// or its current word is leaving in the same cycle.
module trdb_stream_slice #(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign in_ready_o  = ~r_valid | out_ready_i;
  assign out_data_o  = r_data;
  assign out_valid_o = r_valid;

  // The payload only changes on a load, so a stalled word stays stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      r_valid <= 1'b1;
      r_data  <= in_data_i;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trdb_stream_arbiter.sv
// Packet-boundary arbiter merging trace, timer and software words into one tagged
// stream, with a drain-then-confirm flush sequence.
module trdb_stream_arbiter
  import trdb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = TRDB_ARB_MAX_WAIT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] trc_data_i,
  input  logic                  trc_valid_i,
  input  logic                  trc_last_i,
  output logic                  trc_grant_o,
  input  logic [DATA_WIDTH-1:0] tim_data_i,
  input  logic                  tim_valid_i,
  input  logic                  tim_last_i,
  output logic                  tim_grant_o,
  input  logic [DATA_WIDTH-1:0] sw_data_i,
  input  logic                  sw_valid_i,
  output logic                  sw_grant_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            out_src_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  input  logic                  flush_req_i,
  output logic                  flush_confirm_o
);

  localparam int unsigned PW = DATA_WIDTH + 3;
  localparam logic [TRDB_ARB_CNT_W-1:0] MAX_WAIT_C = TRDB_ARB_CNT_W'(MAX_WAIT);

  trdb_arb_state_e           r_state;
  trdb_arb_state_e           w_state_next;
  logic [TRDB_ARB_CNT_W-1:0] r_starv_cnt;
  logic                      r_flush_mask;
  logic                      w_flush;
  logic                      w_can_load;
  logic                      w_sel_trc;
  logic                      w_sel_tim;
  logic                      w_sel_sw;
  logic                      w_any_grant;
  logic [DATA_WIDTH-1:0]     w_mux_data;
  trdb_src_e                 w_mux_src;
  logic                      w_mux_last;
  logic [PW-1:0]             w_slice_out;

  // A flush still asserted right after its confirm is ignored for one cycle.
  assign w_flush = flush_req_i & ~r_flush_mask;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= TRDB_ARB_IDLE;
      r_flush_mask <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_mask <= (r_state == TRDB_ARB_FLUSH_ACK);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TRDB_ARB_IDLE: begin
        if (trc_grant_o && !trc_last_i)      w_state_next = TRDB_ARB_LOCK_TRC;
        else if (tim_grant_o && !tim_last_i) w_state_next = TRDB_ARB_LOCK_TIM;
        else if (w_flush)                    w_state_next = TRDB_ARB_DRAIN;
      end
      TRDB_ARB_LOCK_TRC: begin
        if (trc_grant_o && trc_last_i)
          w_state_next = w_flush ? TRDB_ARB_DRAIN : TRDB_ARB_IDLE;
      end
      TRDB_ARB_LOCK_TIM: begin
        if (tim_grant_o && tim_last_i)
          w_state_next = w_flush ? TRDB_ARB_DRAIN : TRDB_ARB_IDLE;
      end
      TRDB_ARB_DRAIN: begin
        if (!out_valid_o || out_ready_i) w_state_next = TRDB_ARB_FLUSH_ACK;
      end
      default: w_state_next = TRDB_ARB_IDLE;
    endcase
  end

  always_comb begin
    w_sel_trc = 1'b0;
    w_sel_tim = 1'b0;
    w_sel_sw  = 1'b0;
    case (r_state)
      TRDB_ARB_IDLE: begin
        if (enable_i && !w_flush) begin
          if (sw_valid_i && (r_starv_cnt == MAX_WAIT_C)) w_sel_sw  = 1'b1;
          else if (trc_valid_i)                          w_sel_trc = 1'b1;
          else if (tim_valid_i)                          w_sel_tim = 1'b1;
          else if (sw_valid_i)                           w_sel_sw  = 1'b1;
        end
      end
      TRDB_ARB_LOCK_TRC: w_sel_trc = trc_valid_i;
      TRDB_ARB_LOCK_TIM: w_sel_tim = tim_valid_i;
      default: ;
    endcase
  end

  assign trc_grant_o     = w_sel_trc & w_can_load & rst_ni;
  assign tim_grant_o     = w_sel_tim & w_can_load & rst_ni;
  assign sw_grant_o      = w_sel_sw & w_can_load & rst_ni;
  assign w_any_grant     = trc_grant_o | tim_grant_o | sw_grant_o;
  assign flush_confirm_o = (r_state == TRDB_ARB_FLUSH_ACK);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_starv_cnt <= '0;
    end else if (enable_i) begin
      if (sw_grant_o)                                  r_starv_cnt <= '0;
      else if (sw_valid_i && r_starv_cnt != MAX_WAIT_C) r_starv_cnt <= r_starv_cnt + 1'b1;
    end
  end

  always_comb begin
    w_mux_data = trc_data_i;
    w_mux_src  = TRDB_SRC_TRC;
    w_mux_last = trc_last_i;
    if (tim_grant_o) begin
      w_mux_data = tim_data_i;
      w_mux_src  = TRDB_SRC_TIM;
      w_mux_last = tim_last_i;
    end else if (sw_grant_o) begin
      w_mux_data = sw_data_i;
      w_mux_src  = TRDB_SRC_SW;
      w_mux_last = 1'b1;
    end
  end

  trdb_stream_slice #(
    .WIDTH(PW)
  ) u_slice (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_data_i  ({w_mux_data, w_mux_src, w_mux_last}),
    .in_valid_i (w_any_grant),
    .in_ready_o (w_can_load),
    .out_data_o (w_slice_out),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  assign out_data_o = w_slice_out[PW-1:3];
  assign out_src_o  = w_slice_out[2:1];
  assign out_last_o = w_slice_out[0];

endmodule
